// File: rtl/armlp_exec_core.sv
// Execute/memory slice of the ARM-LP single-cycle core: LEGv8-subset decoder, 32-bit ALU, word-addressed data cache.
// Optional feature macro: ALU_NOR_EN enables ALU code 1100 as ~(A|B).
module armlp_exec_core #(
  parameter int DCACHE_DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic [31:0] writeData,
  output logic        unconditionalBranchFlag,
  output logic        branchFlag,
  output logic        memReadFlag,
  output logic        memToRegFlag,
  output logic        memWriteFlag,
  output logic        aluSRC,
  output logic        regWriteFlag,
  output logic [3:0]  aluControlCode,
  output logic [2:0]  opType,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  output logic [4:0]  writeRegister,
  output logic [31:0] result,
  output logic        zeroFlag,
  output logic        carryBit,
  output logic [31:0] readData
);

  localparam int IW = $clog2(DCACHE_DEPTH);

`ifdef ALU_NOR_EN
  localparam logic NOR_EN = 1'b1;
`else
  localparam logic NOR_EN = 1'b0;
`endif

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  logic [10:0]   w_op11;
  logic [32:0]   w_sum;
  logic [32:0]   w_diff;
  logic [IW-1:0] w_index;
  logic [31:0]   r_mem [DCACHE_DEPTH];
  logic [31:0]   r_read_data;

  assign w_op11 = instruction[31:21];

  // Instruction decode; first matching format wins, unknown words decode to all-zero controls.
  always_comb begin
    unconditionalBranchFlag = 1'b0;
    branchFlag              = 1'b0;
    memReadFlag             = 1'b0;
    memToRegFlag            = 1'b0;
    memWriteFlag            = 1'b0;
    aluSRC                  = 1'b0;
    regWriteFlag            = 1'b0;
    aluControlCode          = 4'b0000;
    opType                  = 3'b111;
    readRegister1           = 5'd0;
    readRegister2           = 5'd0;
    writeRegister           = 5'd0;
    if (instruction[31:26] == 6'b000101) begin
      opType                  = 3'b011;
      unconditionalBranchFlag = 1'b1;
    end else if (instruction[31:24] == 8'hB4) begin
      opType         = 3'b100;
      branchFlag     = 1'b1;
      aluControlCode = 4'b0111;
      readRegister1  = instruction[9:5];
      readRegister2  = instruction[4:0];
    end else if ((instruction[31:22] == 10'h244) || (instruction[31:22] == 10'h344)) begin
      opType         = 3'b001;
      aluSRC         = 1'b1;
      regWriteFlag   = 1'b1;
      aluControlCode = (instruction[31:22] == 10'h344) ? 4'b0110 : 4'b0010;
      readRegister1  = instruction[9:5];
      writeRegister  = instruction[4:0];
    end else if ((w_op11 == OP_ADD) || (w_op11 == OP_SUB) ||
                 (w_op11 == OP_AND) || (w_op11 == OP_ORR)) begin
      opType        = 3'b000;
      regWriteFlag  = 1'b1;
      readRegister1 = instruction[9:5];
      readRegister2 = instruction[20:16];
      writeRegister = instruction[4:0];
      case (w_op11)
        OP_ADD:  aluControlCode = 4'b0010;
        OP_SUB:  aluControlCode = 4'b0110;
        OP_AND:  aluControlCode = 4'b0000;
        OP_ORR:  aluControlCode = 4'b0001;
        default: aluControlCode = 4'b0000;
      endcase
    end else if (w_op11 == OP_LDUR) begin
      opType         = 3'b010;
      aluSRC         = 1'b1;
      memReadFlag    = 1'b1;
      memToRegFlag   = 1'b1;
      regWriteFlag   = 1'b1;
      aluControlCode = 4'b0010;
      readRegister1  = instruction[9:5];
      writeRegister  = instruction[4:0];
    end else if (w_op11 == OP_STUR) begin
      opType         = 3'b010;
      aluSRC         = 1'b1;
      memWriteFlag   = 1'b1;
      aluControlCode = 4'b0010;
      readRegister1  = instruction[9:5];
      readRegister2  = instruction[4:0];
    end else begin
      opType = 3'b111;
    end
  end

  assign w_sum  = {1'b0, readData1} + {1'b0, readData2};
  assign w_diff = {1'b0, readData1} + {1'b0, ~readData2} + 33'd1;

  // ALU: carry is bit 32 of the extended add; for subtract 1 means no borrow.
  always_comb begin
    result   = 32'd0;
    carryBit = 1'b0;
    case (aluControlCode)
      4'b0000: result = readData1 & readData2;
      4'b0001: result = readData1 | readData2;
      4'b0010: begin
        result   = w_sum[31:0];
        carryBit = w_sum[32];
      end
      4'b0110: begin
        result   = w_diff[31:0];
        carryBit = w_diff[32];
      end
      4'b0111: result = readData2;
      4'b1100: begin
        if (NOR_EN) begin
          result = ~(readData1 | readData2);
        end else begin
          result = 32'd0;
        end
      end
      default: begin
        result   = 32'd0;
        carryBit = 1'b0;
      end
    endcase
  end

  assign zeroFlag = (result == 32'd0);
  assign w_index  = result[IW+1:2];

  // Data cache and write-back register; loads see the word as it was before this edge's store.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DCACHE_DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
      r_read_data <= 32'd0;
    end else begin
      if (memWriteFlag) begin
        r_mem[w_index] <= writeData;
      end
      if (memReadFlag && memToRegFlag) begin
        r_read_data <= r_mem[w_index];
      end else begin
        r_read_data <= result;
      end
    end
  end

  assign readData = r_read_data;

endmodule

// File: tb/tb_armlp_exec_core.sv
// Scoreboard bench for armlp_exec_core: directed vectors push expectations, a negedge monitor pops and compares.
module tb_armlp_exec_core;

  localparam int S_RESULT = 0;
  localparam int S_ZERO   = 1;
  localparam int S_CARRY  = 2;
  localparam int S_RD     = 3;
  localparam int S_ALUCTL = 4;
  localparam int S_OPTYPE = 5;
  localparam int S_RR1    = 6;
  localparam int S_RR2    = 7;
  localparam int S_WR     = 8;
  localparam int S_FLAGS  = 9;

  typedef struct {
    int          cyc;
    int          sel;
    string       name;
    logic [31:0] exp;
  } item_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction, readData1, readData2, writeData;
  logic        unconditionalBranchFlag, branchFlag, memReadFlag, memToRegFlag;
  logic        memWriteFlag, aluSRC, regWriteFlag;
  logic [3:0]  aluControlCode;
  logic [2:0]  opType;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic [31:0] result, readData;
  logic        zeroFlag, carryBit;

  item_t sb[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;

  armlp_exec_core #(.DCACHE_DEPTH(64)) dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .readData1(readData1), .readData2(readData2), .writeData(writeData),
    .unconditionalBranchFlag(unconditionalBranchFlag), .branchFlag(branchFlag),
    .memReadFlag(memReadFlag), .memToRegFlag(memToRegFlag), .memWriteFlag(memWriteFlag),
    .aluSRC(aluSRC), .regWriteFlag(regWriteFlag), .aluControlCode(aluControlCode),
    .opType(opType), .readRegister1(readRegister1), .readRegister2(readRegister2),
    .writeRegister(writeRegister), .result(result), .zeroFlag(zeroFlag),
    .carryBit(carryBit), .readData(readData)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      S_RESULT: return result;
      S_ZERO:   return {31'd0, zeroFlag};
      S_CARRY:  return {31'd0, carryBit};
      S_RD:     return readData;
      S_ALUCTL: return {28'd0, aluControlCode};
      S_OPTYPE: return {29'd0, opType};
      S_RR1:    return {27'd0, readRegister1};
      S_RR2:    return {27'd0, readRegister2};
      S_WR:     return {27'd0, writeRegister};
      S_FLAGS:  return {25'd0, unconditionalBranchFlag, branchFlag, memReadFlag,
                        memToRegFlag, memWriteFlag, aluSRC, regWriteFlag};
      default:  return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clock) begin
    item_t it;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      checks++;
      act = get_sig(it.sel);
      if (it.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", it.name, it.cyc, cyc);
      end else if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", it.name, act, it.exp, cyc);
      end
    end
  end

  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] wd);
    @(posedge clock);
    #1;
    reset       = rst;
    instruction = ins;
    readData1   = a;
    readData2   = b;
    writeData   = wd;
  endtask

  // lat 0: combinational this cycle; lat 1: registered after the next edge.
  task automatic expect_v(input int sel, input string name, input logic [31:0] v, input int lat);
    item_t it;
    it.cyc  = cyc + lat;
    it.sel  = sel;
    it.name = name;
    it.exp  = v;
    sb.push_back(it);
  endtask

  initial begin
    reset = 1'b1; instruction = 32'd0; readData1 = 32'd0; readData2 = 32'd0; writeData = 32'd0;

    step(1'b1, 32'h0, 32'd0, 32'd0, 32'd0);
    expect_v(S_RD, "reset_rd", 32'd0, 1);

    // ADD X0 = X1 + X2
    step(1'b0, 32'h8B020020, 32'd5, 32'd7, 32'd0);
    expect_v(S_FLAGS,  "add_flags",  32'h01, 0);
    expect_v(S_ALUCTL, "add_aluctl", 32'h2, 0);
    expect_v(S_OPTYPE, "add_optype", 32'h0, 0);
    expect_v(S_RR1,    "add_rr1",    32'd1, 0);
    expect_v(S_RR2,    "add_rr2",    32'd2, 0);
    expect_v(S_WR,     "add_wr",     32'd0, 0);
    expect_v(S_RESULT, "add_result", 32'd12, 0);
    expect_v(S_ZERO,   "add_zero",   32'd0, 0);
    expect_v(S_CARRY,  "add_carry",  32'd0, 0);
    expect_v(S_RD,     "add_rd",     32'd12, 1);

    step(1'b0, 32'hCB020020, 32'h10, 32'h10, 32'd0);
    expect_v(S_ALUCTL, "sub_aluctl", 32'h6, 0);
    expect_v(S_RESULT, "sub_result", 32'd0, 0);
    expect_v(S_ZERO,   "sub_zero",   32'd1, 0);
    expect_v(S_CARRY,  "sub_carry",  32'd1, 0);

    step(1'b0, 32'h8B020020, 32'hFFFFFFFF, 32'd1, 32'd0);
    expect_v(S_RESULT, "addwrap_result", 32'd0, 0);
    expect_v(S_ZERO,   "addwrap_zero",   32'd1, 0);
    expect_v(S_CARRY,  "addwrap_carry",  32'd1, 0);

    step(1'b0, 32'h8A020020, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    expect_v(S_ALUCTL, "and_aluctl", 32'h0, 0);
    expect_v(S_RESULT, "and_result", 32'h0000F000, 0);

    step(1'b0, 32'hAA020020, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    expect_v(S_ALUCTL, "orr_aluctl", 32'h1, 0);
    expect_v(S_RESULT, "orr_result", 32'h0000FFF0, 0);

    // ADDI X1 = X2 + imm / SUBI with borrow
    step(1'b0, 32'h91000C41, 32'd4, 32'd3, 32'd0);
    expect_v(S_FLAGS,  "addi_flags",  32'h03, 0);
    expect_v(S_OPTYPE, "addi_optype", 32'h1, 0);
    expect_v(S_RR1,    "addi_rr1",    32'd2, 0);
    expect_v(S_WR,     "addi_wr",     32'd1, 0);
    expect_v(S_RESULT, "addi_result", 32'd7, 0);
    step(1'b0, 32'hD1000C41, 32'd3, 32'd4, 32'd0);
    expect_v(S_ALUCTL, "subi_aluctl", 32'h6, 0);
    expect_v(S_RESULT, "subi_result", 32'hFFFFFFFF, 0);
    expect_v(S_CARRY,  "subi_carry",  32'd0, 0);

    step(1'b0, 32'hF8000022, 32'h40, 32'd0, 32'hDEADBEEF);
    expect_v(S_FLAGS,  "stur_flags",  32'h06, 0);
    expect_v(S_OPTYPE, "stur_optype", 32'h2, 0);
    expect_v(S_RR2,    "stur_rr2",    32'd2, 0);
    expect_v(S_WR,     "stur_wr",     32'd0, 0);
    expect_v(S_RD,     "stur_rd",     32'h40, 1);

    step(1'b0, 32'hF8400022, 32'h40, 32'd0, 32'd0);
    expect_v(S_FLAGS, "ldur_flags", 32'h1B, 0);
    expect_v(S_WR,    "ldur_wr",    32'd2, 0);
    expect_v(S_RD,    "ldur_rd",    32'hDEADBEEF, 1);

    // Index wrap: 0x144 and 0x45 both map to word 17
    step(1'b0, 32'hF8000022, 32'h144, 32'd0, 32'hCAFEF00D);
    step(1'b0, 32'hF8400022, 32'h45, 32'd0, 32'd0);
    expect_v(S_RD, "wrap_rd", 32'hCAFEF00D, 1);

    step(1'b0, 32'hB4000041, 32'd9, 32'd0, 32'd0);
    expect_v(S_FLAGS,  "cbz_flags",  32'h20, 0);
    expect_v(S_OPTYPE, "cbz_optype", 32'h4, 0);
    expect_v(S_RR1,    "cbz_rr1",    32'd2, 0);
    expect_v(S_RR2,    "cbz_rr2",    32'd1, 0);
    expect_v(S_ALUCTL, "cbz_aluctl", 32'h7, 0);
    expect_v(S_ZERO,   "cbz_zero1",  32'd1, 0);
    step(1'b0, 32'hB4000041, 32'd9, 32'd3, 32'd0);
    expect_v(S_ZERO,   "cbz_zero0",  32'd0, 0);
    expect_v(S_RESULT, "cbz_result", 32'd3, 0);

    step(1'b0, 32'h14000010, 32'd1, 32'd1, 32'd0);
    expect_v(S_FLAGS,  "b_flags",  32'h40, 0);
    expect_v(S_OPTYPE, "b_optype", 32'h3, 0);
    expect_v(S_RR1,    "b_rr1",    32'd0, 0);

    step(1'b0, 32'h00000000, 32'd1, 32'd1, 32'd0);
    expect_v(S_FLAGS,  "bad_flags",  32'h00, 0);
    expect_v(S_OPTYPE, "bad_optype", 32'h7, 0);
    expect_v(S_ALUCTL, "bad_aluctl", 32'h0, 0);
    expect_v(S_RR1,    "bad_rr1",    32'd0, 0);
    expect_v(S_RR2,    "bad_rr2",    32'd0, 0);
    expect_v(S_WR,     "bad_wr",     32'd0, 0);

    // Reset during a store: store suppressed, memory cleared
    step(1'b1, 32'hF8000022, 32'h40, 32'd0, 32'h12345678);
    expect_v(S_RD, "rst_store_rd", 32'd0, 1);
    step(1'b0, 32'hF8400022, 32'h40, 32'd0, 32'd0);
    expect_v(S_RD, "rst_ldur_rd", 32'd0, 1);
    step(1'b0, 32'hF8400022, 32'h144, 32'd0, 32'd0);
    expect_v(S_RD, "rst_ldur2_rd", 32'd0, 1);

    repeat (3) @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never sampled, expected 0x%08h", it.name, it.exp);
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
    end
  end

endmodule

// File: doc/armlp_exec_core.md
# armlp_exec_core

Execute/memory slice of the ARM-LP single-cycle processor. It combines three parts:
- a LEGv8-subset instruction decoder (the controller);
- a 32-bit ALU with zero and carry flags;
- a word-addressed data cache.

Operand preparation supplies register values and store data. The block returns control flags, ALU result and write-back data to operand prep and the PC.

## Interface
- `DCACHE_DEPTH`, 64: data cache words, power of two ≥ 4.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `instruction`  in  32  current instruction word.
- `readData1`  in  32  ALU operand A (Rn value).
- `readData2`  in  32  ALU operand B (register or immediate, already selected upstream).
- `writeData`  in  32  store data.
- `unconditionalBranchFlag`, `branchFlag`, `memReadFlag`, `memToRegFlag`, `memWriteFlag`, `aluSRC`, `regWriteFlag`  out  1 each  decoded controls.
- `aluControlCode`  out  4  ALU operation.
- `opType`  out  3  instruction format.
- `readRegister1`, `readRegister2`, `writeRegister`  out  5 each  register IDs.
- `result`  out  32  ALU result; also the data-cache address.
- `zeroFlag`  out  1  ALU zero flag.
- `carryBit`  out  1  ALU carry flag.
- `readData`  out  32  registered write-back data.
- Clocking/reset: one clock; reset is synchronous and active-high.

## Operation

**Decode** (combinational). op11 = instr[31:21]. Match in this priority order:
1. B: instr[31:26]=000101. opType 011, unconditionalBranchFlag=1.
2. CBZ: instr[31:24]=0xB4. opType 100, branchFlag=1, ALU 0111.
3. ADDI: instr[31:22]=0x244. SUBI: instr[31:22]=0x344. opType 001, aluSRC=1, regWriteFlag=1, ALU 0010 (ADDI) / 0110 (SUBI).
4. op11 = 0x458 ADD / 0x658 SUB / 0x450 AND / 0x550 ORR. opType 000, regWriteFlag=1, ALU 0010 / 0110 / 0000 / 0001.
5. LDUR op11=0x7C2: opType 010, aluSRC, memReadFlag, memToRegFlag, regWriteFlag all 1; ALU 0010.
6. STUR op11=0x7C0: opType 010, aluSRC=1, memWriteFlag=1, ALU 0010.
7. Anything else: opType 111, all flags 0, ALU 0000, all register IDs 0.

Register IDs and flag defaults:
- readRegister1 = instr[9:5], except B → 0.
- readRegister2 = instr[20:16] for R-type; instr[4:0] for STUR and CBZ; otherwise 0.
- writeRegister = instr[4:0] for R, I and LDUR; otherwise 0.
- Flags not listed for a decode are 0.

**ALU** (combinational, A=readData1, B=readData2):
- 0000: A&B, carry 0.
- 0001: A|B, carry 0.
- 0010: A+B, carry = bit 32 of the 33-bit sum.
- 0110: A+~B+1, carry = bit 32 (1 means no borrow).
- 0111: pass B, carry 0.
- 1100: NOR, see Configuration.
- Other codes: result 0, carry 0.
- zeroFlag = (result == 0) for every code.

**Data cache**:
- Word index = result[log2(DCACHE_DEPTH)+1:2]. Low two bits are ignored; higher bits wrap.
- Write: at a rising edge with memWriteFlag=1 and reset=0, mem[index] <= writeData.
- readData register, each rising edge: memReadFlag & memToRegFlag → mem[index], read before that edge's write (old data). Otherwise → result.
- Reset: every memory word and readData cleared to 0. No write occurs during a reset cycle.

## Timing
- Decoder and ALU outputs are combinational. They are valid in the same cycle as instruction/operands and are unaffected by reset.
- readData: 1-cycle latency. Reset value 0.
- Memory write is visible to a load decoded in the next cycle.
- memReadFlag and memWriteFlag high in the same cycle (not produced by the decoder): write proceeds, readData returns the old word.
- Reset asserted mid-sequence: reset overrides any pending store.

## Configuration
- `ALU_NOR_EN` defined: code 1100 gives ~(A|B), carry 0.
- `ALU_NOR_EN` undefined: 1100 behaves as any other undefined code (result 0, zeroFlag 1, carry 0).
- The decoder never emits 1100 in either case.

## Test plan
- ADD, instruction 0x8B020020, A=5, B=7 → regWriteFlag 1, aluControlCode 0010, opType 000, readRegister1 1, readRegister2 2, writeRegister 0, result 12, zeroFlag 0, carryBit 0. Next edge: readData 12.
- SUB, instruction 0xCB020020, A=B=0x10 → aluControlCode 0110, result 0, zeroFlag 1, carryBit 1. ADD with A=0xFFFFFFFF, B=1 → result 0, zeroFlag 1, carryBit 1.
- STUR, instruction 0xF8000022, A=0x40, B=0, writeData=0xDEADBEEF, one edge → memWriteFlag 1, readRegister2 2. Then LDUR, instruction 0xF8400022, same operands → after the edge readData=0xDEADBEEF, writeRegister 2.
- CBZ, instruction 0xB4000041, B=0 → branchFlag 1, opType 100, readRegister2 1, aluControlCode 0111, zeroFlag 1. With B=3 → zeroFlag 0.
- B, instruction 0x14000010 → unconditionalBranchFlag 1, opType 011. Instruction 0x00000000 → opType 111, all flags 0.
- reset=1 while STUR 0xF8000022 stores 0x12345678 at A=0x40 → readData 0. After reset, LDUR at 0x40 → readData 0.
